// File: rtl/hilo_div_ctrl.sv
// Sequencer between the execute stage and the signed divider. Launches a divide,
// waits a fixed latency, then writes quotient to LO and remainder to HI. Also
// handles MTHI/MTLO and stalls the CPU while a divide is in flight.
module hilo_div_ctrl #(
  parameter int unsigned DIV_WAIT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_div,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_e;

  localparam logic [3:0] CntInit = 4'(DIV_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        zero_q, zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;

  // State and datapath registers; reset aborts any divide without touching HI/LO beyond clearing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      zero_q     <= zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  // Next-state logic and control outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    zero_d     = zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    div_start  = 1'b0;
    done       = 1'b0;
    stall      = (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (op_div) begin
          // Divide takes priority; any simultaneous move is dropped.
          stall      = 1'b1;
          dividend_d = rs_val;
          divisor_d  = rt_val;
          zero_d     = (rt_val == 32'd0);
          state_d    = (rt_val == 32'd0) ? StWrite : StIssue;
        end else begin
          if (op_mthi) hi_d = rs_val;
          if (op_mtlo) lo_d = rs_val;
        end
      end
      StIssue: begin
        div_start = 1'b1;
        cnt_d     = CntInit;
        state_d   = StWait;
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrite: begin
        done = 1'b1;
        if (zero_q) begin
          // Divide by zero: divider never started, fixed result.
          lo_d = 32'hFFFF_FFFF;
          hi_d = dividend_q;
        end else begin
          hi_d = div_r;
          lo_d = div_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a scoreboard of expected HI/LO results.
module tb_hilo_div_ctrl;

  localparam int unsigned DivWait = 2;

  logic        clock;
  logic        reset;
  logic        op_div;
  logic        op_mthi;
  logic        op_mtlo;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  hilo_t sb_q[$];
  logic [31:0] hi_m, lo_m;
  int n_checks;
  int n_fail;

  hilo_div_ctrl #(.DIV_WAIT(DivWait)) dut (
    .clock       (clock),
    .reset       (reset),
    .op_div      (op_div),
    .op_mthi     (op_mthi),
    .op_mtlo     (op_mtlo),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .div_q       (div_q),
    .div_r       (div_r),
    .div_start   (div_start),
    .div_dividend(div_dividend),
    .div_divisor (div_divisor),
    .stall       (stall),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Divider stand-in: combinational signed divide of the latched operands.
  always_comb begin
    div_q = '0;
    div_r = '0;
    if (div_divisor != 32'd0) begin
      div_q = $signed(div_dividend) / $signed(div_divisor);
      div_r = $signed(div_dividend) % $signed(div_divisor);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_div(input string tag, input logic [31:0] rs, input logic [31:0] rt,
                         input logic with_mthi, input logic inject);
    int    start_cyc = -1;
    int    start_cnt = 0;
    int    done_cyc  = -1;
    int    low_stall = 0;
    bit    is_zero;
    hilo_t e;
    is_zero = (rt == 32'd0);
    if (is_zero) begin
      e.hi = rs;
      e.lo = 32'hFFFF_FFFF;
    end else begin
      e.hi = $signed(rs) % $signed(rt);
      e.lo = $signed(rs) / $signed(rt);
    end
    sb_q.push_back(e);
    op_div  = 1'b1;
    op_mthi = with_mthi;
    rs_val  = rs;
    rt_val  = rt;
    @(negedge clock);
    check_eq({tag, "_stall_c0"}, 32'(stall), 32'd1);
    check_eq({tag, "_start_c0"}, 32'(div_start), 32'd0);
    @(posedge clock);
    #1;
    op_div  = 1'b0;
    op_mthi = 1'b0;
    for (int c = 1; c <= int'(DivWait) + 10; c++) begin
      @(negedge clock);
      if (div_start) begin
        start_cnt++;
        if (start_cyc < 0) start_cyc = c;
      end
      if (!stall) low_stall++;
      if (done) begin
        done_cyc = c;
        check_eq({tag, "_dividend"}, div_dividend, rs);
        check_eq({tag, "_divisor"}, div_divisor, rt);
        break;
      end
      if (inject && c == 2) begin
        op_div = 1'b1;
        rs_val = 32'd55;
        rt_val = 32'd11;
      end
      if (inject && c == 3) op_div = 1'b0;
    end
    check_eq({tag, "_start_cnt"}, 32'(start_cnt), is_zero ? 32'd0 : 32'd1);
    check_eq({tag, "_start_cyc"}, 32'(start_cyc), is_zero ? 32'hFFFF_FFFF : 32'd1);
    check_eq({tag, "_done_cyc"}, 32'(done_cyc), is_zero ? 32'd1 : 32'(DivWait + 2));
    check_eq({tag, "_stall_low"}, 32'(low_stall), 32'd0);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_hi"}, hi, e.hi);
      check_eq({tag, "_lo"}, lo, e.lo);
      hi_m = e.hi;
      lo_m = e.lo;
    end
    check_eq({tag, "_stall_after"}, 32'(stall), 32'd0);
    check_eq({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  task automatic do_move(input string tag, input logic mthi, input logic mtlo,
                         input logic [31:0] val);
    op_mthi = mthi;
    op_mtlo = mtlo;
    rs_val  = val;
    @(negedge clock);
    check_eq({tag, "_stall"}, 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    if (mthi) hi_m = val;
    if (mtlo) lo_m = val;
    check_eq({tag, "_hi"}, hi, hi_m);
    check_eq({tag, "_lo"}, lo, lo_m);
  endtask

  initial begin
    int done_seen;
    n_checks = 0;
    n_fail   = 0;
    hi_m     = '0;
    lo_m     = '0;
    reset    = 1'b0;
    op_div   = 1'b0;
    op_mthi  = 1'b0;
    op_mtlo  = 1'b0;
    rs_val   = '0;
    rt_val   = '0;
    #2;
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_start", 32'(div_start), 32'd0);
    check_eq("rst_dividend", div_dividend, 32'd0);
    check_eq("rst_divisor", div_divisor, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    run_div("d7_2", 32'd7, 32'd2, 1'b0, 1'b0);
    run_div("dm7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_div("dm7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_div("dz", 32'd100, 32'd0, 1'b0, 1'b0);

    do_move("mthi", 1'b1, 1'b0, 32'hDEAD_BEEF);
    do_move("mtlo", 1'b0, 1'b1, 32'h1234_5678);
    do_move("mtboth", 1'b1, 1'b1, 32'hA5A5_0F0F);
    run_div("div_mthi", 32'd20, 32'd6, 1'b1, 1'b0);

    // Reset asserted during WAIT of 9/3.
    op_div = 1'b1;
    rs_val = 32'd9;
    rt_val = 32'd3;
    @(posedge clock);
    #1;
    op_div = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rr_hi", hi, 32'd0);
    check_eq("rr_lo", lo, 32'd0);
    check_eq("rr_stall", 32'(stall), 32'd0);
    check_eq("rr_done", 32'(done), 32'd0);
    check_eq("rr_dividend", div_dividend, 32'd0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clock);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done || div_start || stall) done_seen++;
    end
    check_eq("rr_idle", 32'(done_seen), 32'd0);
    @(posedge clock);
    #1;
    run_div("d9_3", 32'd9, 32'd3, 1'b0, 1'b0);

    run_div("inject", 32'd1000, 32'd7, 1'b0, 1'b1);
    check_eq("inject_dividend", div_dividend, 32'd1000);
    check_eq("inject_divisor", div_divisor, 32'd7);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
